// File: rtl/ecg_pkg.sv
// Shared definitions for the pooling/packing datapath: widths, controller
// state codes, legal window sizes and the layer-end FSM state type.
package ecg_pkg;

   localparam int BYTE_W   = 8;
   localparam int HALF_W   = 32;
   localparam int EIGHTB_W = 64;
   localparam int LANES    = EIGHTB_W / BYTE_W;

   localparam logic [5:0] CS_CAL       = 6'd4;
   localparam logic [5:0] CS_LAYER_END = 6'd8;

   localparam logic [3:0] P_2 = 4'd2;
   localparam logic [3:0] P_4 = 4'd4;
   localparam logic [3:0] P_5 = 4'd5;
   localparam logic [3:0] P_8 = 4'd8;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_FLUSH = 2'd2
   } pool_state_e;

   function automatic logic p_legal(input logic [3:0] p);
      return (p == P_2) || (p == P_4) || (p == P_5) || (p == P_8);
   endfunction

   function automatic logic signed [BYTE_W-1:0] smax8(input logic signed [BYTE_W-1:0] a,
                                                      input logic signed [BYTE_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pool_max_tree.sv
// Masked signed int8 max over one 8-byte window, split into a pairwise first
// level and a 4-to-1 second level so a pipeline register can sit between them.
module pool_max_tree
   import ecg_pkg::*;
(
   input  logic [EIGHTB_W-1:0]      win_i,
   input  logic [3:0]               p_i,
   output logic [HALF_W-1:0]        pair_o,
   input  logic [HALF_W-1:0]        pair_i,
   output logic signed [BYTE_W-1:0] max_o
);

   logic signed [BYTE_W-1:0] masked [LANES];
   logic signed [BYTE_W-1:0] m01;
   logic signed [BYTE_W-1:0] m23;

   // Bytes beyond the window size become -128 so they never win.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         masked[i] = (4'(i) < p_i) ? win_i[i*BYTE_W +: BYTE_W] : 8'h80;
      end
      pair_o = '0;
      for (int k = 0; k < LANES/2; k++) begin
         pair_o[k*BYTE_W +: BYTE_W] = smax8(masked[2*k], masked[2*k+1]);
      end
   end

   always_comb begin
      m01   = smax8(pair_i[0*BYTE_W +: BYTE_W], pair_i[1*BYTE_W +: BYTE_W]);
      m23   = smax8(pair_i[2*BYTE_W +: BYTE_W], pair_i[3*BYTE_W +: BYTE_W]);
      max_o = smax8(m01, m23);
   end

endmodule

// File: rtl/pool_pack_unit.sv
// Two-stage max-pool (optional ReLU) followed by an 8-lane byte packer that
// emits 64-bit SRAM write words and flushes a partial word at layer end.
module pool_pack_unit
   import ecg_pkg::*;
#(
   parameter int         ADDR_W       = 10,
   parameter logic [5:0] LAYER_END_CS = CS_LAYER_END,
   parameter logic [5:0] CAL_CS       = CS_CAL
)(
   input  logic                clk_cal,
   input  logic                rst_cal_n,
   input  logic [5:0]          or_cs,
   input  logic [EIGHTB_W-1:0] pool_idata,
   input  logic                pool_idata_vld,
   input  logic [3:0]          P,
   input  logic                relu_en,
   output logic [EIGHTB_W-1:0] pool_wdata,
   output logic [LANES-1:0]    pool_wbe,
   output logic                pool_wdata_vld,
   output logic [ADDR_W-1:0]   pool_waddr,
   output logic                pool_busy,
   output logic                pool_err
);

   function automatic logic signed [BYTE_W-1:0] relu8(input logic signed [BYTE_W-1:0] x,
                                                      input logic en);
      return (en && (x < 0)) ? 8'sd0 : x;
   endfunction

   pool_state_e              state_q, state_d;
   logic                     end_cs_q, end_cs_d, end_now, accept;
   logic [HALF_W-1:0]        pair_w, pair_p1_q, pair_p1_d;
   logic                     vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
   logic signed [BYTE_W-1:0] max_w, res_p2_q, res_p2_d;
   logic [2:0]               pack_cnt_q, pack_cnt_d;
   logic [EIGHTB_W-1:0]      pack_word_q, pack_word_d;
   logic [EIGHTB_W-1:0]      wdata_q, wdata_d;
   logic [LANES-1:0]         wbe_q, wbe_d;
   logic                     wvld_q, wvld_d;
   logic                     flush_strobe_q, flush_strobe_d;
   logic [ADDR_W-1:0]        waddr_q, waddr_d;
   logic                     err_q, err_d;

   pool_max_tree u_max_tree (
      .win_i  (pool_idata),
      .p_i    (P),
      .pair_o (pair_w),
      .pair_i (pair_p1_q),
      .max_o  (max_w)
   );

   always_comb begin
      end_now        = (or_cs == LAYER_END_CS);
      accept         = pool_idata_vld && (state_q == ST_RUN) && p_legal(P);
      state_d        = state_q;
      end_cs_d       = end_now;
      // Stage 1: pairwise maxes of the masked window
      pair_p1_d      = accept ? pair_w : pair_p1_q;
      vld_p1_d       = accept;
      // Stage 2: final max and ReLU
      vld_p2_d       = vld_p1_q;
      res_p2_d       = vld_p1_q ? relu8(max_w, relu_en) : res_p2_q;
      pack_cnt_d     = pack_cnt_q;
      pack_word_d    = pack_word_q;
      wdata_d        = wdata_q;
      wbe_d          = wbe_q;
      wvld_d         = 1'b0;
      flush_strobe_d = 1'b0;
      waddr_d        = waddr_q;
      err_d          = err_q;

      if (pool_idata_vld && (state_q == ST_RUN) && !p_legal(P)) begin
         err_d = 1'b1;
      end

      // Packer: lanes fill in order; the word is cleared once emitted so a
      // partial flush naturally carries zeros in its unused lanes.
      if (vld_p2_q) begin
         pack_word_d[{pack_cnt_q, 3'b000} +: BYTE_W] = res_p2_q;
         pack_cnt_d = pack_cnt_q + 3'd1;
         if (pack_cnt_q == 3'd7) begin
            wdata_d     = pack_word_d;
            wbe_d       = 8'hFF;
            wvld_d      = 1'b1;
            pack_word_d = '0;
         end
      end

      // Address advances after the strobe; a flush strobe resets it instead.
      if (wvld_q) begin
         waddr_d = flush_strobe_q ? '0 : waddr_q + 1'b1;
      end

      unique case (state_q)
         ST_RUN: begin
            if (end_now && !end_cs_q) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!vld_p1_q && !vld_p2_q) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (pack_cnt_q != 3'd0) begin
               wdata_d        = pack_word_q;
               wbe_d          = (8'd1 << pack_cnt_q) - 8'd1;
               wvld_d         = 1'b1;
               flush_strobe_d = 1'b1;
            end else begin
               waddr_d = '0;
            end
            pack_cnt_d  = 3'd0;
            pack_word_d = '0;
            err_d       = 1'b0;
            state_d     = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk_cal or negedge rst_cal_n) begin
      if (!rst_cal_n) begin
         state_q        <= ST_RUN;
         end_cs_q       <= 1'b0;
         pair_p1_q      <= '0;
         vld_p1_q       <= 1'b0;
         vld_p2_q       <= 1'b0;
         res_p2_q       <= '0;
         pack_cnt_q     <= '0;
         pack_word_q    <= '0;
         wdata_q        <= '0;
         wbe_q          <= '0;
         wvld_q         <= 1'b0;
         flush_strobe_q <= 1'b0;
         waddr_q        <= '0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         end_cs_q       <= end_cs_d;
         pair_p1_q      <= pair_p1_d;
         vld_p1_q       <= vld_p1_d;
         vld_p2_q       <= vld_p2_d;
         res_p2_q       <= res_p2_d;
         pack_cnt_q     <= pack_cnt_d;
         pack_word_q    <= pack_word_d;
         wdata_q        <= wdata_d;
         wbe_q          <= wbe_d;
         wvld_q         <= wvld_d;
         flush_strobe_q <= flush_strobe_d;
         waddr_q        <= waddr_d;
         err_q          <= err_d;
      end
   end

   assign pool_wdata     = wdata_q;
   assign pool_wbe       = wbe_q;
   assign pool_wdata_vld = wvld_q;
   assign pool_waddr     = waddr_q;
   assign pool_err       = err_q;
   assign pool_busy      = vld_p1_q | vld_p2_q | (pack_cnt_q != 3'd0) | (state_q != ST_RUN);

endmodule

// File: tb/tb_pool_pack_unit.sv
// Randomized bench for pool_pack_unit with a window-level reference model
// and a queue of expected SRAM writes.
module tb_pool_pack_unit;

   localparam int AW = 10;

   logic          clk_cal = 1'b0;
   logic          rst_cal_n = 1'b0;
   logic [5:0]    or_cs = 6'd0;
   logic [63:0]   pool_idata = '0;
   logic          pool_idata_vld = 1'b0;
   logic [3:0]    P = 4'd8;
   logic          relu_en = 1'b0;
   logic [63:0]   pool_wdata;
   logic [7:0]    pool_wbe;
   logic          pool_wdata_vld;
   logic [AW-1:0] pool_waddr;
   logic          pool_busy;
   logic          pool_err;

   pool_pack_unit #(.ADDR_W(AW)) dut (
      .clk_cal        (clk_cal),
      .rst_cal_n      (rst_cal_n),
      .or_cs          (or_cs),
      .pool_idata     (pool_idata),
      .pool_idata_vld (pool_idata_vld),
      .P              (P),
      .relu_en        (relu_en),
      .pool_wdata     (pool_wdata),
      .pool_wbe       (pool_wbe),
      .pool_wdata_vld (pool_wdata_vld),
      .pool_waddr     (pool_waddr),
      .pool_busy      (pool_busy),
      .pool_err       (pool_err)
   );

   typedef struct {
      logic [63:0]   d;
      logic [7:0]    be;
      logic [AW-1:0] a;
      int            c;
   } wr_t;

   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   int            last_edge = 0;
   wr_t           obs_q[$];
   wr_t           exp_q[$];
   wr_t           mon_w;
   logic [7:0]    m_lanes[$];
   logic [AW-1:0] m_addr = '0;

   always #5 clk_cal = ~clk_cal;
   always @(posedge clk_cal) cyc <= cyc + 1;

   always @(negedge clk_cal) begin
      if (pool_wdata_vld === 1'b1) begin
         mon_w.d  = pool_wdata;
         mon_w.be = pool_wbe;
         mon_w.a  = pool_waddr;
         mon_w.c  = cyc;
         obs_q.push_back(mon_w);
      end
   end

   // Reference: a window's result is the largest signed byte among the first
   // P bytes, clamped at zero when ReLU is on.
   function automatic logic [7:0] ref_window(input logic [63:0] d, input int p, input logic relu);
      int best = -128;
      for (int i = 0; i < p; i++) begin
         int b = int'($signed(d[8*i +: 8]));
         if (b > best) best = b;
      end
      if (relu && best < 0) best = 0;
      return 8'(best);
   endfunction

   task automatic model_emit(input logic [7:0] be);
      wr_t e;
      e.d = '0;
      for (int i = 0; i < m_lanes.size(); i++) e.d[8*i +: 8] = m_lanes[i];
      e.be = be;
      e.a  = m_addr;
      e.c  = 0;
      exp_q.push_back(e);
      m_addr = m_addr + 1'b1;
      m_lanes.delete();
   endtask

   task automatic model_beat(input logic [63:0] d, input logic [3:0] p);
      if (p == 4'd2 || p == 4'd4 || p == 4'd5 || p == 4'd8) begin
         m_lanes.push_back(ref_window(d, int'(p), relu_en));
         if (m_lanes.size() == 8) model_emit(8'hFF);
      end
   endtask

   task automatic model_flush();
      if (m_lanes.size() > 0) model_emit(8'((1 << m_lanes.size()) - 1));
      m_addr = '0;
   endtask

   task automatic model_reset();
      m_lanes.delete();
      m_addr = '0;
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_cal);
         #1;
      end
   endtask

   task automatic send_beat(input logic [63:0] d, input logic [3:0] p);
      pool_idata     = d;
      P              = p;
      pool_idata_vld = 1'b1;
      @(posedge clk_cal);
      #1;
      last_edge      = cyc;
      pool_idata_vld = 1'b0;
      model_beat(d, p);
   endtask

   function automatic logic [3:0] rand_p();
      logic [3:0] tbl [4] = '{4'd2, 4'd4, 4'd5, 4'd8};
      return tbl[$urandom_range(0, 3)];
   endfunction

   task automatic test_reset();
      rst_cal_n = 1'b0;
      idle(2);
      total += 6;
      if (pool_wdata !== 64'd0) begin bad++; $display("FAIL rst_wdata: got %h want 0", pool_wdata); end
      if (pool_wbe !== 8'd0) begin bad++; $display("FAIL rst_wbe: got %h want 0", pool_wbe); end
      if (pool_wdata_vld !== 1'b0) begin bad++; $display("FAIL rst_vld: got %b want 0", pool_wdata_vld); end
      if (pool_waddr !== '0) begin bad++; $display("FAIL rst_waddr: got %0d want 0", pool_waddr); end
      if (pool_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", pool_busy); end
      if (pool_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", pool_err); end
      rst_cal_n = 1'b1;
      idle(1);
      model_reset();
   endtask

   task automatic test_p8_word();
      logic [63:0] d;
      int          r, val, lane;
      relu_en = 1'b0;
      for (int k = 0; k < 8; k++) begin
         val  = k - 3;
         lane = (k * 3 + 1) % 8;
         for (int j = 0; j < 8; j++) begin
            r = int'($urandom_range(0, val + 127)) - 128;
            d[8*j +: 8] = 8'(r);
         end
         d[8*lane +: 8] = 8'(val);
         send_beat(d, 4'd8);
      end
      idle(5);
      total++;
      if (obs_q.size() != 1) begin
         bad++;
         $display("FAIL p8_count: got %0d strobes want 1", obs_q.size());
      end else begin
         total += 4;
         if (obs_q[0].d !== 64'h04030201_00FFFEFD) begin bad++; $display("FAIL p8_data: got %h want 0403020100fffefd", obs_q[0].d); end
         if (obs_q[0].be !== 8'hFF) begin bad++; $display("FAIL p8_wbe: got %h want ff", obs_q[0].be); end
         if (obs_q[0].a !== '0) begin bad++; $display("FAIL p8_waddr: got %0d want 0", obs_q[0].a); end
         if (obs_q[0].c != last_edge + 2) begin bad++; $display("FAIL p8_latency: got cycle %0d want %0d", obs_q[0].c, last_edge + 2); end
      end
      total++;
      if (exp_q.size() != 1 || (obs_q.size() == 1 && obs_q[0].d !== exp_q[0].d)) begin
         bad++;
         $display("FAIL p8_model: got %0d strobes want model %0d", obs_q.size(), exp_q.size());
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_mask();
      send_beat(64'h7F807F05_80808080, 4'd5);
      send_beat(64'h7F7F7F7F_7F7FF0E0, 4'd2);
      for (int k = 0; k < 6; k++) send_beat({$urandom, $urandom}, rand_p());
      idle(5);
      total++;
      if (obs_q.size() != exp_q.size()) begin
         bad++;
         $display("FAIL mask_count: got %0d want %0d", obs_q.size(), exp_q.size());
      end
      if (obs_q.size() > 0) begin
         total += 3;
         if (obs_q[0].d[7:0] !== 8'h05) begin bad++; $display("FAIL mask_p5: got %h want 05", obs_q[0].d[7:0]); end
         if (obs_q[0].d[15:8] !== 8'hF0) begin bad++; $display("FAIL mask_p2: got %h want f0", obs_q[0].d[15:8]); end
         if (obs_q[0].a !== 10'd1) begin bad++; $display("FAIL mask_waddr: got %0d want 1", obs_q[0].a); end
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         total++;
         if (obs_q[i].d !== exp_q[i].d || obs_q[i].be !== exp_q[i].be || obs_q[i].a !== exp_q[i].a) begin
            bad++;
            $display("FAIL mask_word%0d: got %h/%h/%0d want %h/%h/%0d", i, obs_q[i].d, obs_q[i].be, obs_q[i].a,
                     exp_q[i].d, exp_q[i].be, exp_q[i].a);
         end
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_relu();
      relu_en = 1'b1;
      send_beat(64'h90909090_90909090, 4'd4);
      send_beat(64'h80808080_80338080, 4'd4);
      for (int k = 0; k < 6; k++) send_beat({$urandom, $urandom}, rand_p());
      idle(5);
      total++;
      if (obs_q.size() != exp_q.size()) begin
         bad++;
         $display("FAIL relu_count: got %0d want %0d", obs_q.size(), exp_q.size());
      end
      if (obs_q.size() > 0) begin
         total += 2;
         if (obs_q[0].d[7:0] !== 8'h00) begin bad++; $display("FAIL relu_neg: got %h want 00", obs_q[0].d[7:0]); end
         if (obs_q[0].d[15:8] !== 8'h33) begin bad++; $display("FAIL relu_pos: got %h want 33", obs_q[0].d[15:8]); end
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         total++;
         if (obs_q[i].d !== exp_q[i].d || obs_q[i].be !== exp_q[i].be || obs_q[i].a !== exp_q[i].a) begin
            bad++;
            $display("FAIL relu_word%0d: got %h/%h/%0d want %h/%h/%0d", i, obs_q[i].d, obs_q[i].be, obs_q[i].a,
                     exp_q[i].d, exp_q[i].be, exp_q[i].a);
         end
      end
      obs_q.delete();
      exp_q.delete();
      relu_en = 1'b0;
   endtask

   task automatic test_random();
      relu_en = 1'($urandom_range(0, 1));
      for (int k = 0; k < 60; k++) begin
         send_beat({$urandom, $urandom}, rand_p());
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
      idle(5);
      total++;
      if (obs_q.size() != exp_q.size()) begin
         bad++;
         $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         total++;
         if (obs_q[i].d !== exp_q[i].d || obs_q[i].be !== exp_q[i].be || obs_q[i].a !== exp_q[i].a) begin
            bad++;
            $display("FAIL rand_word%0d: got %h/%h/%0d want %h/%h/%0d", i, obs_q[i].d, obs_q[i].be, obs_q[i].a,
                     exp_q[i].d, exp_q[i].be, exp_q[i].a);
         end
      end
      obs_q.delete();
      exp_q.delete();
      relu_en = 1'b0;
   endtask

   task automatic test_back_to_back();
      rst_cal_n = 1'b0;
      idle(1);
      rst_cal_n = 1'b1;
      idle(1);
      model_reset();
      for (int k = 0; k < 11; k++) send_beat({$urandom, $urandom}, 4'd4);
      or_cs = 6'd8;
      model_flush();
      idle(5);
      or_cs = 6'd0;
      idle(6);
      total++;
      if (obs_q.size() != 2) begin
         bad++;
         $display("FAIL b2b_count: got %0d strobes want 2", obs_q.size());
      end else begin
         total += 5;
         if (obs_q[0].a !== 10'd0 || obs_q[0].be !== 8'hFF) begin bad++; $display("FAIL b2b_full: got a=%0d be=%h want a=0 be=ff", obs_q[0].a, obs_q[0].be); end
         if (obs_q[1].be !== 8'h07) begin bad++; $display("FAIL b2b_wbe: got %h want 07", obs_q[1].be); end
         if (obs_q[1].a !== 10'd1) begin bad++; $display("FAIL b2b_waddr: got %0d want 1", obs_q[1].a); end
         if (obs_q[1].d[63:24] !== 40'd0) begin bad++; $display("FAIL b2b_zero: got %h want 0", obs_q[1].d[63:24]); end
         if (obs_q[1].d !== exp_q[1].d || obs_q[0].d !== exp_q[0].d) begin
            bad++;
            $display("FAIL b2b_data: got %h,%h want %h,%h", obs_q[0].d, obs_q[1].d, exp_q[0].d, exp_q[1].d);
         end
      end
      total += 2;
      if (pool_waddr !== '0) begin bad++; $display("FAIL b2b_waddr_after: got %0d want 0", pool_waddr); end
      if (pool_busy !== 1'b0) begin bad++; $display("FAIL b2b_busy: got %b want 0", pool_busy); end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_illegal_p();
      send_beat({$urandom, $urandom}, 4'd3);
      idle(3);
      total += 3;
      if (pool_err !== 1'b1) begin bad++; $display("FAIL ill_err: got %b want 1", pool_err); end
      if (pool_busy !== 1'b0) begin bad++; $display("FAIL ill_busy: got %b want 0", pool_busy); end
      if (obs_q.size() != 0) begin bad++; $display("FAIL ill_nostrobe: got %0d want 0", obs_q.size()); end
      for (int k = 0; k < 8; k++) send_beat({$urandom, $urandom}, rand_p());
      idle(4);
      total += 2;
      if (obs_q.size() != 1 || exp_q.size() != 1) begin
         bad++;
         $display("FAIL ill_count: got %0d want %0d", obs_q.size(), exp_q.size());
      end else if (obs_q[0].d !== exp_q[0].d || obs_q[0].a !== exp_q[0].a) begin
         bad++;
         $display("FAIL ill_word: got %h/%0d want %h/%0d", obs_q[0].d, obs_q[0].a, exp_q[0].d, exp_q[0].a);
      end
      if (pool_err !== 1'b1) begin bad++; $display("FAIL ill_sticky: got %b want 1", pool_err); end
      obs_q.delete();
      exp_q.delete();
      or_cs = 6'd8;
      model_flush();
      idle(1);
      or_cs = 6'd0;
      idle(5);
      total += 3;
      if (pool_err !== 1'b0) begin bad++; $display("FAIL ill_clear: got %b want 0", pool_err); end
      if (obs_q.size() != 0) begin bad++; $display("FAIL ill_noflush: got %0d strobes want 0", obs_q.size()); end
      if (pool_waddr !== m_addr) begin bad++; $display("FAIL ill_waddr: got %0d want %0d", pool_waddr, m_addr); end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 7; k++) send_beat({$urandom, $urandom}, 4'd8);
      total++;
      if (pool_busy !== 1'b1) begin bad++; $display("FAIL mid_busy_pre: got %b want 1", pool_busy); end
      rst_cal_n = 1'b0;
      #1;
      total += 5;
      if (pool_wdata !== 64'd0) begin bad++; $display("FAIL mid_wdata: got %h want 0", pool_wdata); end
      if (pool_wbe !== 8'd0) begin bad++; $display("FAIL mid_wbe: got %h want 0", pool_wbe); end
      if (pool_wdata_vld !== 1'b0) begin bad++; $display("FAIL mid_vld: got %b want 0", pool_wdata_vld); end
      if (pool_busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", pool_busy); end
      if (pool_waddr !== '0 || pool_err !== 1'b0) begin bad++; $display("FAIL mid_addr_err: got %0d/%b want 0/0", pool_waddr, pool_err); end
      @(posedge clk_cal);
      #1;
      rst_cal_n = 1'b1;
      model_reset();
      idle(20);
      total++;
      if (obs_q.size() != 0) begin bad++; $display("FAIL mid_nostrobe: got %0d want 0", obs_q.size()); end
   endtask

   initial begin
      test_reset();
      test_p8_word();
      test_mask();
      test_relu();
      test_random();
      test_back_to_back();
      test_illegal_p();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
